// File: rtl/multicycle_control.sv
// Main control FSM for the 8-bit multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back with memory wait and timeout handling.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_load,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_force_add,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R,
    S_EXEC_I, S_WB_I, S_ADDR, S_MEM_RD,
    S_WB_MEM, S_MEM_WR, S_BRANCH, S_ILLEGAL
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             waiting, timeout;

  always_comb begin
    waiting = 1'b0;
    if (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR)
      waiting = !mem_ready;
    timeout = waiting && (cnt == CNT_W'(MEM_TIMEOUT - 1));
    cnt_nx  = (waiting && !timeout) ? cnt + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_force_add = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    bus_err       = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read      = 1'b1;
        alu_src_b     = 2'b01;
        alu_force_add = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b     = 2'b11;
        alu_force_add = 1'b1;
        unique case (1'b1)
          opcode == 3'b000: state_nx = S_EXEC_R;
          opcode == 3'b001: state_nx = S_EXEC_I;
          opcode == 3'b010: state_nx = S_ADDR;
          opcode == 3'b011: state_nx = S_ADDR;
          opcode == 3'b100: state_nx = S_BRANCH;
          default:          state_nx = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        state_nx  = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nx  = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_force_add = 1'b1;
        state_nx      = (opcode == 3'b011) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_nx = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
        instr_done    = 1'b1;
        state_nx      = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
    // Abort the stalled access; a fetch timeout retries the same PC.
    if (timeout) begin
      bus_err  = 1'b1;
      state_nx = S_FETCH;
    end
    if (!rst_n) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_force_add = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      bus_err       = 1'b0;
    end
  end

  assign pc_load = pc_write | (pc_write_cond & zero);

endmodule
